wb_mem_arbiter: RTL
===================

WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, range 2..255: stalled-cycle count before the arbiter aborts the bus cycle.
REQ-002 wb_clk_i  in  1  system clock; all state changes on its rising edge.
REQ-003 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-004 m0_adr_i / m1_adr_i  in  32  master address; m0 = CPU data port, m1 = Ethernet DMA master.
REQ-005 m0_dat_i / m1_dat_i  in  32  master write data.
REQ-006 m0_dat_o / m1_dat_o  out  32  read data to master.
REQ-007 m0_sel_i / m1_sel_i  in  4  byte selects.
REQ-008 m0_we_i / m1_we_i  in  1  write enable.
REQ-009 m0_cyc_i / m1_cyc_i  in  1  bus-cycle request.
REQ-010 m0_stb_i / m1_stb_i  in  1  transfer strobe.
REQ-011 m0_ack_o / m1_ack_o  out  1  transfer acknowledge.
REQ-012 m0_err_o / m1_err_o  out  1  transfer error.
REQ-013 s_adr_o  out  32,  s_dat_o  out  32,  s_sel_o  out  4,  s_we_o  out  1: memory-slave request fields.
REQ-014 s_cyc_o  out  1,  s_stb_o  out  1: memory-slave cycle and strobe.
REQ-015 s_dat_i  in  32,  s_ack_i  in  1,  s_err_i  in  1: memory-slave response.
REQ-016 grant_o  out  2  one-hot owner: 01 = m0, 10 = m1, 00 = none.
REQ-017 timeout_o  out  1  one-cycle pulse on each timeout abort.

Function
REQ-018 States: IDLE, OWN0, OWN1; grant_o registered and equal to {state==OWN1, state==OWN0}.
REQ-019 IDLE with exactly one mN_cyc_i high: go to OWNN on the next edge (one-cycle grant latency).
REQ-020 IDLE with both cyc_i high: grant the master opposite to last_owner; last_owner updates on each grant.
REQ-021 OWNN holds while mN_cyc_i is high, including multi-transfer bursts and stb gaps; non-owner requests wait.
REQ-022 OWNN with mN_cyc_i low: return to IDLE on that edge; no direct owner-to-owner handover, so at least one IDLE cycle separates owners.
REQ-023 Owner dropping cyc_i with stb pending and no ack: released anyway; timeout counter cleared.
REQ-024 In OWNN, s_cyc_o, s_stb_o, s_adr_o, s_dat_o, s_sel_o and s_we_o combinationally follow master N; in IDLE all are 0.
REQ-025 m0_dat_o = m1_dat_o = s_dat_i at all times.
REQ-026 mN_ack_o = s_ack_i & ~s_err_i & (state==OWNN) & mN_stb_i; non-owner ack and err are always 0.
REQ-027 mN_err_o = ((s_err_i & mN_stb_i) | timeout abort) & (state==OWNN); s_err_i beats s_ack_i when both are high.
REQ-028 Timeout counter, 8 bits: increments each cycle s_stb_o=1 with s_ack_i=0 and s_err_i=0; clears on ack, err, s_stb_o=0, or state change.
REQ-029 Counter reaching TIMEOUT_CYCLES in the same cycle: owner's err_o and timeout_o high for that cycle, s_stb_o forced 0 for that cycle, counter clears, ownership kept until the owner drops cyc_i.
REQ-030 No combinational path from mN_cyc_i to grant_o.

Reset
REQ-031 On wb_rst_i high, asynchronously: state = IDLE, last_owner = 1 (m0 wins first conflict), counter = 0.
REQ-032 During reset all outputs are 0, except mN_dat_o, which equals s_dat_i.
REQ-033 Reset mid-transfer aborts immediately with no ack or err issued; the first grant after release takes the normal one-cycle latency.

Verification
REQ-034 After reset, m0 and m1 cyc/stb both raised on the same edge -> grant_o=01 next cycle; m1 sees no ack until m0 drops cyc, then grant_o=00 for one cycle, then 10.
REQ-035 m1 4-beat burst, cyc held, slave acks every cycle; m0 requests at beat 2 -> m0_ack_o stays 0 throughout, m0 granted 2 cycles after m1 cyc falls.
REQ-036 Both masters request continuously for 6 single transfers each -> grant alternates 01,10,01,... with no master granted twice in a row.
REQ-037 TIMEOUT_CYCLES=4, slave never acks on m0 read -> m0_err_o and timeout_o high exactly on the 4th stalled cycle, s_stb_o=0 that cycle, grant_o still 01.
REQ-038 s_ack_i and s_err_i high together during an m1 write -> m1_err_o=1, m1_ack_o=0, m0 outputs 0.
REQ-039 wb_rst_i pulsed mid-m1 burst -> grant_o, s_cyc_o and ack/err outputs go to 0 before the next clock edge; the next conflict grants m0.

Source files
------------

// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter in front of a single memory slave: CPU data port (m0)
// and Ethernet DMA (m1), with round-robin conflict resolution and a stall timeout.
module wb_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e     state_q, state_d;
  logic       last_owner_q, last_owner_d;  // 1: m1 was granted last
  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  logic own0, own1, req_stb, stall, timeout;

  assign own0    = (state_q == OWN0);
  assign own1    = (state_q == OWN1);
  assign grant_o = {own1, own0};

  // The abort fires on the TIMEOUT_CYCLES-th consecutive stalled cycle, so it
  // compares against the count already accumulated by the previous stalls.
  assign req_stb   = (own0 & m0_stb_i) | (own1 & m1_stb_i);
  assign stall     = req_stb & ~s_ack_i & ~s_err_i;
  assign timeout   = stall & (tmo_cnt_q == TMO_LAST);
  assign timeout_o = timeout;

  assign s_cyc_o = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
  assign s_stb_o = req_stb & ~timeout;
  assign s_adr_o = own0 ? m0_adr_i : (own1 ? m1_adr_i : 32'd0);
  assign s_dat_o = own0 ? m0_dat_i : (own1 ? m1_dat_i : 32'd0);
  assign s_sel_o = own0 ? m0_sel_i : (own1 ? m1_sel_i : 4'd0);
  assign s_we_o  = (own0 & m0_we_i) | (own1 & m1_we_i);

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = own0 & m0_stb_i & s_ack_i & ~s_err_i;
  assign m1_ack_o = own1 & m1_stb_i & s_ack_i & ~s_err_i;
  assign m0_err_o = own0 & ((m0_stb_i & s_err_i) | timeout);
  assign m1_err_o = own1 & ((m1_stb_i & s_err_i) | timeout);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_owner_q)) begin
          state_d      = OWN0;
          last_owner_d = 1'b0;
        end else if (m1_cyc_i) begin
          state_d      = OWN1;
          last_owner_d = 1'b1;
        end
      end
      OWN0:    if (!m0_cyc_i) state_d = IDLE;
      OWN1:    if (!m1_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    tmo_cnt_d = (stall && !timeout && (state_d == state_q)) ? tmo_cnt_q + 8'd1 : 8'd0;
  end

  // NOTE: state uses non-blocking assignments and an asynchronous reset so the
  // bus is released the instant reset rises, without waiting for a clock edge.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      tmo_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

endmodule
